// File: rtl/demux_pkt_dispatcher_if.sv
// Beat-stream bundle for the 1:8 packet dispatcher: one upstream valid/ready stream
// and eight downstream lanes sharing data/last with per-lane valid/ready.
interface demux_pkt_dispatcher_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [2:0]    in_dest;
  logic          in_last;
  logic [7:0]    out_valid;
  logic [7:0]    out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    output in_valid, in_data, in_dest, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_dest, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/demux_pkt_dispatcher.sv
// Packet-level 1:8 dispatcher: locks each packet to one lane (by header dest or
// round-robin over enabled lanes), drops packets for disabled lanes, one-beat output register.
module demux_pkt_dispatcher #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [7:0]             lane_en,
  demux_pkt_dispatcher_if.slave  bus,
  output logic                   busy,
  output logic [CNT_W-1:0]       drop_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  // Returns {found, lane}: first enabled lane at or after ptr, wrapping modulo 8.
  function automatic logic [3:0] rr_pick(input logic [7:0] en, input logic [2:0] ptr);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (en[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  logic [7:0]      out_valid_r;
  logic [DW-1:0]   out_data_r;
  logic            out_last_r;
  logic [2:0]      lane_r;
  logic [2:0]      rr_ptr_r;
  logic [CNT_W-1:0] drop_cnt_r;
  logic            busy_r;

  logic            drain_s;
  logic            free_s;
  logic            in_ready_s;
  logic [3:0]      rr_res_s;
  logic            grant_s;
  logic [2:0]      sel_lane_s;
  logic            load_s;
  logic [2:0]      load_lane_s;
  logic            drop_evt_s;
  logic            rr_upd_s;

  // Next-state, handshake and output-register load decisions.
  always_comb begin
    state_nxt_s = state_r;
    in_ready_s  = 1'b0;
    load_s      = 1'b0;
    load_lane_s = lane_r;
    drop_evt_s  = 1'b0;
    rr_upd_s    = 1'b0;
    drain_s     = out_valid_r[lane_r] & bus.out_ready[lane_r];
    free_s      = ~(|out_valid_r) | drain_s;
    rr_res_s    = rr_pick(lane_en, rr_ptr_r);
    if (mode) begin
      grant_s    = rr_res_s[3];
      sel_lane_s = rr_res_s[2:0];
    end else begin
      grant_s    = lane_en[bus.in_dest];
      sel_lane_s = bus.in_dest;
    end

    case (state_r)
      IDLE: begin
        in_ready_s = free_s;
        if (bus.in_valid && in_ready_s) begin
          if (grant_s) begin
            load_s      = 1'b1;
            load_lane_s = sel_lane_s;
            rr_upd_s    = mode;
            state_nxt_s = bus.in_last ? IDLE : FWD;
          end else begin
            drop_evt_s  = 1'b1;
            state_nxt_s = bus.in_last ? IDLE : DROP;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FWD: begin
        in_ready_s = free_s;
        if (bus.in_valid && in_ready_s) begin
          load_s      = 1'b1;
          load_lane_s = lane_r;
          state_nxt_s = bus.in_last ? IDLE : FWD;
        end else begin
          state_nxt_s = FWD;
        end
      end
      DROP: begin
        // Dropped beats never touch the output register, so a beat held for the
        // previous packet keeps draining independently.
        in_ready_s = 1'b1;
        if (bus.in_valid && bus.in_last) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        in_ready_s  = 1'b0;
      end
    endcase
  end

  // State, output register, round-robin pointer and drop counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_valid_r <= 8'd0;
      out_data_r  <= {DW{1'b0}};
      out_last_r  <= 1'b0;
      lane_r      <= 3'd0;
      rr_ptr_r    <= 3'd0;
      drop_cnt_r  <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      if (load_s) begin
        out_valid_r <= 8'd1 << load_lane_s;
        out_data_r  <= bus.in_data;
        out_last_r  <= bus.in_last;
        lane_r      <= load_lane_s;
      end else if (drain_s) begin
        out_valid_r <= 8'd0;
      end
      if (rr_upd_s) begin
        rr_ptr_r <= sel_lane_s + 3'd1;
      end
      if (drop_evt_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
        drop_cnt_r <= drop_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  assign busy          = busy_r;
  assign drop_cnt      = drop_cnt_r;

endmodule

// File: tb/tb_demux_pkt_dispatcher.sv
// Self-checking bench for demux_pkt_dispatcher: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a packet-level model.
module tb_demux_pkt_dispatcher;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [7:0]  lane_en;
  logic        busy;
  logic [15:0] drop_cnt;

  demux_pkt_dispatcher_if #(.DW(8)) ifc ();

  demux_pkt_dispatcher #(.DW(8), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .lane_en  (lane_en),
    .bus      (ifc),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Packet-level model: what the output holding slot contains and where the packet stands.
  typedef struct packed {
    logic        held;
    logic [2:0]  lane;
    logic [7:0]  data;
    logic        last;
    logic        open;
    logic        dropping;
    logic [2:0]  rr;
    logic [15:0] drops;
  } mstate_t;

  mstate_t m = '0;

  function automatic logic exp_ready(mstate_t s, logic [7:0] ordy);
    if (s.dropping) return 1'b1;
    return !s.held || ordy[s.lane];
  endfunction

  function automatic mstate_t model_next(mstate_t s, logic rst, logic vld, logic [7:0] d,
                                         logic [2:0] dest, logic lst, logic md,
                                         logic [7:0] en, logic [7:0] ordy);
    mstate_t n;
    int      lsel;
    bit      ok;
    if (!rst) begin
      n = '0;
      return n;
    end
    n = s;
    if (s.held && ordy[s.lane]) n.held = 1'b0;
    if (vld && exp_ready(s, ordy)) begin
      if (!s.open) begin
        ok = 1'b0;
        lsel = 0;
        if (!md) begin
          lsel = int'(dest);
          ok   = en[lsel];
        end else begin
          for (int k = 0; k < 8; k++) begin
            if (!ok && en[(int'(s.rr) + k) % 8]) begin
              ok   = 1'b1;
              lsel = (int'(s.rr) + k) % 8;
            end
          end
        end
        n.open = !lst;
        if (ok) begin
          n.held     = 1'b1;
          n.lane     = 3'(lsel);
          n.data     = d;
          n.last     = lst;
          n.dropping = 1'b0;
          if (md) n.rr = 3'((lsel + 1) % 8);
        end else begin
          n.dropping = !lst;
          if (s.drops != 16'hFFFF) n.drops = s.drops + 16'd1;
        end
      end else if (s.dropping) begin
        if (lst) begin
          n.open     = 1'b0;
          n.dropping = 1'b0;
        end
      end else begin
        n.held = 1'b1;
        n.data = d;
        n.last = lst;
        if (lst) n.open = 1'b0;
      end
    end
    return n;
  endfunction

  // Advance the model on every rising edge from the inputs the DUT sees.
  always @(posedge clk) begin
    m <= model_next(m, rst_n, ifc.in_valid, ifc.in_data, ifc.in_dest, ifc.in_last,
                    mode, lane_en, ifc.out_ready);
  end

  // Compare DUT against the model mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_out_valid", {24'd0, ifc.out_valid}, m.held ? (32'd1 << m.lane) : 32'd0);
      chk("m_out_data",  {24'd0, ifc.out_data}, {24'd0, m.data});
      chk("m_out_last",  {31'd0, ifc.out_last}, {31'd0, m.last});
      chk("m_busy",      {31'd0, busy}, {31'd0, m.open});
      chk("m_drop_cnt",  {16'd0, drop_cnt}, {16'd0, m.drops});
      chk("m_in_ready",  {31'd0, ifc.in_ready}, {31'd0, exp_ready(m, ifc.out_ready)});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] dst, input logic lst,
                      output int waits);
    logic acc;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    ifc.in_dest  = dst;
    ifc.in_last  = lst;
    waits = 0;
    acc   = 1'b0;
    while (!acc && waits < 50) begin
      #1;
      acc = ifc.in_ready;
      cyc();
      if (!acc) waits++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    ifc.in_valid = 1'b0;
  endtask

  logic [7:0] t3_exp [4];
  int w;

  initial begin
    t3_exp = '{8'h01, 8'h04, 8'h10, 8'h01};
    rst_n         = 1'b0;
    mode          = 1'b0;
    lane_en       = 8'hFF;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 8'h00;
    ifc.in_dest   = 3'd0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 8'hFF;

    // T1: reset with in_valid held high
    cyc();
    cyc();
    chk("t1_out_valid", {24'd0, ifc.out_valid}, 32'h0);
    chk("t1_drop_cnt",  {16'd0, drop_cnt}, 32'h0);
    chk("t1_busy",      {31'd0, busy}, 32'h0);
    chk("t1_in_ready",  {31'd0, ifc.in_ready}, 32'h1);
    rst_n        = 1'b1;
    ifc.in_valid = 1'b0;
    check_en     = 1'b1;
    cyc();

    // T2: 3-beat packet routed by dest to lane 5
    send(8'h11, 3'd5, 1'b0, w);
    chk("t2_valid1", {24'd0, ifc.out_valid}, 32'h20);
    chk("t2_data1",  {24'd0, ifc.out_data}, 32'h11);
    chk("t2_busy1",  {31'd0, busy}, 32'h1);
    send(8'h22, 3'd0, 1'b0, w);
    chk("t2_data2",  {24'd0, ifc.out_data}, 32'h22);
    send(8'h33, 3'd0, 1'b1, w);
    chk("t2_valid3", {24'd0, ifc.out_valid}, 32'h20);
    chk("t2_data3",  {24'd0, ifc.out_data}, 32'h33);
    chk("t2_last3",  {31'd0, ifc.out_last}, 32'h1);
    chk("t2_busy3",  {31'd0, busy}, 32'h0);
    cyc();
    chk("t2_drained", {24'd0, ifc.out_valid}, 32'h0);

    // T3: round-robin over lanes 0,2,4
    mode    = 1'b1;
    lane_en = 8'h15;
    for (int i = 0; i < 4; i++) begin
      send(8'h40 + 8'(i), 3'd7, 1'b1, w);
      chk("t3_lane", {24'd0, ifc.out_valid}, {24'd0, t3_exp[i]});
    end

    // T4: packet to disabled lane 3 dropped, then lane 1 delivered
    mode    = 1'b0;
    lane_en = 8'hF7;
    send(8'hA1, 3'd3, 1'b0, w);
    chk("t4_wait1",  w, 32'd0);
    chk("t4_valid1", {24'd0, ifc.out_valid}, 32'h0);
    chk("t4_drop1",  {16'd0, drop_cnt}, 32'h1);
    chk("t4_busy1",  {31'd0, busy}, 32'h1);
    send(8'hA2, 3'd6, 1'b1, w);
    chk("t4_wait2",  w, 32'd0);
    chk("t4_valid2", {24'd0, ifc.out_valid}, 32'h0);
    chk("t4_drop2",  {16'd0, drop_cnt}, 32'h1);
    send(8'hB1, 3'd1, 1'b1, w);
    chk("t4_lane1",  {24'd0, ifc.out_valid}, 32'h02);
    chk("t4_dataB1", {24'd0, ifc.out_data}, 32'hB1);

    // T5: backpressure on lane 2
    lane_en       = 8'hFF;
    ifc.out_ready = 8'hFB;
    send(8'hC1, 3'd2, 1'b0, w);
    chk("t5_valid", {24'd0, ifc.out_valid}, 32'h04);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'hC2;
    ifc.in_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t5_stall_ready", {31'd0, ifc.in_ready}, 32'h0);
      chk("t5_hold_data",   {24'd0, ifc.out_data}, 32'hC1);
      chk("t5_hold_valid",  {24'd0, ifc.out_valid}, 32'h04);
      cyc();
    end
    ifc.out_ready = 8'hFF;
    send(8'hC2, 3'd0, 1'b1, w);
    chk("t5_wait",  w, 32'd0);
    chk("t5_data2", {24'd0, ifc.out_data}, 32'hC2);
    chk("t5_last2", {31'd0, ifc.out_last}, 32'h1);

    // T6: lane switch without a bubble, then reset mid-packet
    send(8'hD1, 3'd6, 1'b1, w);
    chk("t6_lane6", {24'd0, ifc.out_valid}, 32'h40);
    send(8'hE1, 3'd1, 1'b1, w);
    chk("t6_wait",  w, 32'd0);
    chk("t6_lane1", {24'd0, ifc.out_valid}, 32'h02);
    chk("t6_dataE", {24'd0, ifc.out_data}, 32'hE1);
    send(8'hF1, 3'd3, 1'b0, w);
    send(8'hF2, 3'd3, 1'b0, w);
    ifc.in_valid = 1'b1;
    rst_n = 1'b0;
    cyc();
    chk("t6_rst_valid", {24'd0, ifc.out_valid}, 32'h0);
    chk("t6_rst_busy",  {31'd0, busy}, 32'h0);
    chk("t6_rst_drop",  {16'd0, drop_cnt}, 32'h0);
    chk("t6_rst_data",  {24'd0, ifc.out_data}, 32'h0);
    chk("t6_rst_ready", {31'd0, ifc.in_ready}, 32'h1);
    rst_n        = 1'b1;
    ifc.in_valid = 1'b0;
    cyc();

    // Randomized traffic, including mid-packet mode/mask changes and rare resets
    for (int c = 0; c < 4000; c++) begin
      ifc.in_valid = ($urandom_range(0, 9) < 7);
      ifc.in_data  = 8'($urandom);
      ifc.in_dest  = 3'($urandom);
      ifc.in_last  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) mode = 1'($urandom);
      if ($urandom_range(0, 3) == 0)
        lane_en = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      ifc.out_ready = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      rst_n = ($urandom_range(0, 799) != 0);
      cyc();
    end
    rst_n        = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 8'hFF;
    cyc();
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
